bag_sequencer: RTL and testbench

//  Controller for the 7-bag piece randomiser (bag). Clears the bag, fills it with
//  7 distinct pieces drawn from an LFSR, then serves them one per request to the game FSM.

---
 rtl/tetris_pkg.sv | 46 ++++
 rtl/lfsr16.sv | 34 +++
 rtl/bag_sequencer.sv | 155 +++++++++++++++
 tb/tb_bag_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared types and helpers for the 7-bag piece sequencer.
//                piece_t, piece count, "no piece" code, sequencer state
//                encoding, fallback priority encoder and slot multiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam int     NUM_PIECES = 7;
    localparam piece_t PIECE_NONE = 3'd7;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FILL  = 2'd1,
        WAIT  = 2'd2,
        SERVE = 2'd3
    } seq_state_t;

    // Lowest index whose used bit is clear. Scanning from the top down lets the
    // last hit (the lowest index) win.
    function automatic piece_t lowest_unused(input logic [NUM_PIECES-1:0] mask);
        piece_t p;
        p = '0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!mask[i]) p = piece_t'(i);
        end
        return p;
    endfunction

    // Slot k of the packed bag contents (slot k = bits [3k+2:3k]).
    function automatic piece_t slot_of(input logic [3*NUM_PIECES-1:0] contents,
                                       input logic [2:0]              k);
        piece_t s;
        s = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if (k == 3'(i)) s = contents[3*i +: 3];
        end
        return s;
    endfunction

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Galois LFSR, taps 16'hB400, advances every cycle.
//                load has priority over advance; a zero seed loads SEED so
//                the register can never lock up at zero.
//  Ports       : clk, reset (async, active-high), load, seed[15:0],
//                value[15:0]
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    localparam logic [15:0] C_TAPS = 16'hB400;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            value <= (seed == 16'h0) ? SEED : seed;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? C_TAPS : 16'h0);
        end
    end

endmodule : lfsr16
`default_nettype wire

// File: rtl/bag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bag_sequencer
//  Description : Controller for the 7-bag piece randomiser. Clears the bag,
//                fills it with 7 distinct LFSR-drawn pieces (falling back to
//                the lowest unused piece after MAX_TRIES rejected draws),
//                then serves the slots one per piece_req handshake and
//                refills when the bag is exhausted.
//  Ports       : clk, reset (async, active-high)
//                seed_load, seed[15:0]      LFSR reseed
//                piece_req / piece_valid / piece_out[2:0]   game side
//                bag_newbag, bag_newpiece, bag_piece[2:0],
//                bag_done, bag_contents[20:0]               bag side
//                preview_valid, preview[2:0]  (BAG_PREVIEW_EN only)
//  Macro       : BAG_PREVIEW_EN - adds the next-piece preview outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module bag_sequencer
    import tetris_pkg::*;
#(
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        piece_req,
    output logic        piece_valid,
    output logic [2:0]  piece_out,
    output logic        bag_newbag,
    output logic        bag_newpiece,
    output logic [2:0]  bag_piece,
    input  logic        bag_done,
`ifdef BAG_PREVIEW_EN
    input  logic [20:0] bag_contents,
    output logic        preview_valid,
    output logic [2:0]  preview
`else
    input  logic [20:0] bag_contents
`endif
);

    localparam int TRIES_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] C_TRIES_MAX = TRIES_W'(MAX_TRIES);

    seq_state_t         r_state;
    logic [6:0]         r_used;
    logic [2:0]         r_count;
    logic [TRIES_W-1:0] r_tries;
    logic [2:0]         r_rd_idx;

    logic [15:0]        w_lfsr;
    logic               w_lfsr_unused;
    piece_t             w_cand;
    logic [7:0]         w_used8;
    logic               w_cand_ok;
    logic               w_strobe;
    piece_t             w_strobe_piece;
    logic               w_xfer;

    lfsr16 #(
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (seed),
        .value (w_lfsr)
    );

    // Only the low three bits form the candidate.
    assign w_lfsr_unused = ^w_lfsr[15:3];
    assign w_cand        = w_lfsr[2:0];

    // Code 7 maps onto a permanently-set bit so it is rejected like a used piece.
    assign w_used8   = {1'b1, r_used};
    assign w_cand_ok = (w_cand != PIECE_NONE) && !w_used8[w_cand];

    // Once the retry budget is spent the fallback takes precedence over the
    // draw; with MAX_TRIES = 0 this makes the fill order deterministic 0..6.
    always_comb begin
        w_strobe       = 1'b0;
        w_strobe_piece = '0;
        if (r_state == FILL) begin
            if (r_tries == C_TRIES_MAX) begin
                w_strobe       = 1'b1;
                w_strobe_piece = lowest_unused(r_used);
            end else if (w_cand_ok) begin
                w_strobe       = 1'b1;
                w_strobe_piece = w_cand;
            end
        end
    end

    assign w_xfer = (r_state == SERVE) && piece_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= CLEAR;
            r_used   <= '0;
            r_count  <= '0;
            r_tries  <= '0;
            r_rd_idx <= '0;
        end else begin
            unique case (r_state)
                CLEAR: begin
                    r_used   <= '0;
                    r_count  <= '0;
                    r_tries  <= '0;
                    r_rd_idx <= '0;
                    r_state  <= FILL;
                end
                FILL: begin
                    if (w_strobe) begin
                        r_used  <= r_used | (7'b1 << w_strobe_piece);
                        r_count <= r_count + 3'd1;
                        r_tries <= '0;
                        if (r_count == 3'(NUM_PIECES - 1)) r_state <= WAIT;
                    end else begin
                        r_tries <= r_tries + TRIES_W'(1);
                    end
                end
                WAIT: begin
                    if (bag_done) r_state <= SERVE;
                end
                SERVE: begin
                    if (w_xfer) begin
                        if (r_rd_idx == 3'(NUM_PIECES - 1)) begin
                            r_state <= CLEAR;
                        end else begin
                            r_rd_idx <= r_rd_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // CLEAR is the reset state, so the clear pulse is masked while reset is
    // held; it appears in the first cycle after release.
    assign bag_newbag   = (r_state == CLEAR) && !reset;
    assign bag_newpiece = w_strobe;
    assign bag_piece    = w_strobe_piece;
    assign piece_valid  = (r_state == SERVE);
    assign piece_out    = piece_valid ? slot_of(bag_contents, r_rd_idx) : 3'd0;

`ifdef BAG_PREVIEW_EN
    assign preview_valid = (r_state == SERVE) && (r_rd_idx < 3'(NUM_PIECES - 1));
    assign preview       = preview_valid ? slot_of(bag_contents, r_rd_idx + 3'd1) : 3'd0;
`endif

endmodule : bag_sequencer
`default_nettype wire

// File: tb/tb_bag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bag_sequencer
//  Description : Directed bench for bag_sequencer. Two instances share the
//                clock: u_dut_a (default MAX_TRIES) and u_dut_0 (MAX_TRIES=0,
//                deterministic fill, piece_req tied high). Each has a small
//                behavioural bag model.
//  Macro       : BAG_PREVIEW_EN - also checks the preview outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bag_sequencer;

    logic        clk;
    logic        rst_a, rst_0;
    logic        seed_load_a, seed_load_0;
    logic [15:0] seed_a, seed_0;
    logic        req_a, req_0;
    logic        valid_a, valid_0;
    logic [2:0]  pout_a, pout_0;
    logic        newbag_a, newbag_0;
    logic        newpiece_a, newpiece_0;
    logic [2:0]  piece_a, piece_0;
    logic        done_a, done_0;
    logic [20:0] contents_a = '0;
    logic [20:0] contents_0 = '0;
    logic [2:0]  cnt_a = '0;
    logic [2:0]  cnt_0 = '0;
`ifdef BAG_PREVIEW_EN
    logic        pv_a, pv_0;
    logic [2:0]  prev_a, prev_0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int overlap_a = 0;
    int overlap_0 = 0;

    bag_sequencer u_dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .seed_load    (seed_load_a),
        .seed         (seed_a),
        .piece_req    (req_a),
        .piece_valid  (valid_a),
        .piece_out    (pout_a),
        .bag_newbag   (newbag_a),
        .bag_newpiece (newpiece_a),
        .bag_piece    (piece_a),
        .bag_done     (done_a),
`ifdef BAG_PREVIEW_EN
        .bag_contents (contents_a),
        .preview_valid(pv_a),
        .preview      (prev_a)
`else
        .bag_contents (contents_a)
`endif
    );

    bag_sequencer #(.MAX_TRIES(0)) u_dut_0 (
        .clk          (clk),
        .reset        (rst_0),
        .seed_load    (seed_load_0),
        .seed         (seed_0),
        .piece_req    (req_0),
        .piece_valid  (valid_0),
        .piece_out    (pout_0),
        .bag_newbag   (newbag_0),
        .bag_newpiece (newpiece_0),
        .bag_piece    (piece_0),
        .bag_done     (done_0),
`ifdef BAG_PREVIEW_EN
        .bag_contents (contents_0),
        .preview_valid(pv_0),
        .preview      (prev_0)
`else
        .bag_contents (contents_0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bag models: clear on newbag, append on newpiece, full at 7 pieces.
    always @(posedge clk) begin
        if (newbag_a) begin
            cnt_a <= '0; contents_a <= '0;
        end else if (newpiece_a && cnt_a < 3'd7) begin
            contents_a[3*cnt_a +: 3] <= piece_a; cnt_a <= cnt_a + 3'd1;
        end
        if (newbag_0) begin
            cnt_0 <= '0; contents_0 <= '0;
        end else if (newpiece_0 && cnt_0 < 3'd7) begin
            contents_0[3*cnt_0 +: 3] <= piece_0; cnt_0 <= cnt_0 + 3'd1;
        end
    end
    assign done_a = (cnt_a == 3'd7);
    assign done_0 = (cnt_0 == 3'd7);

    always @(negedge clk) begin
        if (newbag_a && newpiece_a) overlap_a++;
        if (newbag_0 && newpiece_0) overlap_0++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mask_of(input logic [20:0] s);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 7; i++) m = m | (8'b1 << s[3*i +: 3]);
        return m;
    endfunction

    // Records up to 7 strobes of u_dut_a in order, starting with the current cycle.
    task automatic capture_fill(output logic [20:0] seq, output int n);
        seq = '0;
        n   = 0;
        for (int k = 0; k < 300 && n < 7; k++) begin
            if (newpiece_a) begin
                seq[3*n +: 3] = piece_a;
                n++;
            end
            if (n < 7) tick;
        end
    endtask

    logic [20:0] seq_a, s1, s2, s3;
    int          n_a, n1, n2, n3, cnt3, done_c, valid_c;
    logic        seen_done, seen_valid;

    initial begin
        rst_a = 1'b1; rst_0 = 1'b1;
        seed_load_a = 1'b0; seed_load_0 = 1'b0;
        seed_a = '0; seed_0 = '0;
        req_a = 1'b0; req_0 = 1'b1;
        tick; tick;

        // Reset state: every output low although the FSM sits in CLEAR.
        check_eq("rst_newbag",   {newbag_a, newbag_0}, 0);
        check_eq("rst_newpiece", {newpiece_a, newpiece_0}, 0);
        check_eq("rst_valid",    {valid_a, valid_0}, 0);
        check_eq("rst_pout",     {pout_a, pout_0, piece_a, piece_0}, 0);
        check_eq("rst_lfsr",     u_dut_a.u_lfsr.value, 16'hACE1);

        rst_a = 1'b0; rst_0 = 1'b0;
        #1;
        seq_a = '0; n_a = 0; seen_done = 1'b0; seen_valid = 1'b0; done_c = 0; valid_c = 0;
        for (int c = 0; c < 200; c++) begin
            // Deterministic instance: CLEAR @0, strobes 0..6 @1..7, WAIT @8,
            // serve 0..6 @9..15 with req held high, CLEAR again @16.
            if (c < 9)  check_eq("d0_no_valid_before_serve", valid_0, 0);
            if (c == 0) check_eq("d0_newbag", newbag_0, 1);
            if (c >= 1 && c <= 7) begin
                check_eq("d0_strobe", newpiece_0, 1);
                check_eq("d0_fill_order", piece_0, c - 1);
            end
            if (c == 8) check_eq("d0_wait_no_strobe", newpiece_0, 0);
            if (c == 9) check_eq("d0_contents", contents_0, 21'o6543210);
            if (c >= 9 && c <= 15) begin
                check_eq("d0_valid", valid_0, 1);
                check_eq("d0_serve", pout_0, c - 9);
`ifdef BAG_PREVIEW_EN
                check_eq("d0_preview_valid", pv_0, (c < 15) ? 1 : 0);
                check_eq("d0_preview", prev_0, (c < 15) ? c - 8 : 0);
`endif
            end
            if (c == 16) begin
                check_eq("d0_reclear", newbag_0, 1);
                check_eq("d0_valid_drop", valid_0, 0);
            end

            if (c == 0) check_eq("a_newbag_first", newbag_a, 1);
            if (newpiece_a) begin
                if (n_a < 7) seq_a[3*n_a +: 3] = piece_a;
                n_a++;
            end
            if (done_a && !seen_done)   begin seen_done = 1'b1;  done_c = c;  end
            if (valid_a && !seen_valid) begin seen_valid = 1'b1; valid_c = c; end
            if (c >= 17 && seen_valid) break;
            tick;
        end

        check_eq("a_valid_seen",     seen_valid, 1);
        check_eq("a_strobe_count",   n_a, 7);
        check_eq("a_distinct",       mask_of(seq_a), 8'h7F);
        check_eq("a_used_mask",      u_dut_a.r_used, 7'h7F);
        check_eq("a_valid_after_done", valid_c - done_c, 1);
        check_eq("a_latency_min",    (valid_c >= 9) ? 1 : 0, 1);
        check_eq("a_first_piece",    pout_a, seq_a[2:0]);

        // LFSR reseed: zero seed substitutes the reset seed; then one load and advances.
        seed_load_a = 1'b1; seed_a = 16'h0000;
        tick;
        check_eq("lfsr_zero_seed", u_dut_a.u_lfsr.value, 16'hACE1);
        seed_a = 16'h5A5A;
        tick;
        seed_load_a = 1'b0;
        check_eq("lfsr_load", u_dut_a.u_lfsr.value, 16'h5A5A);
        tick;
        check_eq("lfsr_step1", u_dut_a.u_lfsr.value, 16'h2D2D);
        tick;
        check_eq("lfsr_step2", u_dut_a.u_lfsr.value, 16'hA296);

        // One transfer advances to slot 1; no strobes while serving.
        check_eq("a_serve_no_strobe", newpiece_a, 0);
        req_a = 1'b1;
        tick;
        req_a = 1'b0;
        check_eq("a_second_piece", pout_a, seq_a[5:3]);

        // Same seed twice -> identical bag.
        rst_a = 1'b1; tick; rst_a = 1'b0; #1;
        seed_load_a = 1'b1; seed_a = 16'h1234;
        tick;
        seed_load_a = 1'b0;
        check_eq("seed_loaded", u_dut_a.u_lfsr.value, 16'h1234);
        capture_fill(s1, n1);
        rst_a = 1'b1; tick; rst_a = 1'b0; #1;
        seed_load_a = 1'b1; seed_a = 16'h1234;
        tick;
        seed_load_a = 1'b0;
        capture_fill(s2, n2);
        check_eq("seed_run1_count", n1, 7);
        check_eq("seed_run2_count", n2, 7);
        check_eq("seed_repeat_seq", s2, s1);
        check_eq("seed_run_distinct", mask_of(s1), 8'h7F);

        // Reset mid-fill after 3 strobes.
        rst_a = 1'b1; tick; rst_a = 1'b0; #1;
        tick;
        cnt3 = 0;
        for (int k = 0; k < 300 && cnt3 < 3; k++) begin
            if (newpiece_a) cnt3++;
            tick;
        end
        check_eq("midfill_count", u_dut_a.r_count, 3);
        rst_a = 1'b1;
        #1;
        check_eq("midfill_rst_outputs", {newbag_a, newpiece_a, piece_a, valid_a, pout_a}, 0);
        check_eq("midfill_rst_used", u_dut_a.r_used, 0);
        tick;
        rst_a = 1'b0;
        #1;
        check_eq("midfill_reclear", newbag_a, 1);
        tick;
        capture_fill(s3, n3);
        check_eq("refill_count", n3, 7);
        check_eq("refill_distinct", mask_of(s3), 8'h7F);

        check_eq("overlap_a", overlap_a, 0);
        check_eq("overlap_0", overlap_0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bag_sequencer
`default_nettype wire
